instruction_cr_compressor: RTL

INSTRUCTION_CR_COMPRESSOR -- requirements
Module: instruction_cr_compressor

---
 rtl/instruction_cr_compressor_pkg.sv | 27 ++
 rtl/instruction_cr_compressor_encode.sv | 78 +++++++
 rtl/instruction_cr_compressor.sv | 104 ++++++++++
 3 files changed

// File: rtl/instruction_cr_compressor_pkg.sv
// Shared constants and types for the CR-format instruction compressor.
// Holds opcodes, CR funct4 codes and the packer state encoding.
package instruction_cr_compressor_pkg;

  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ADD  = 7'b0110011;

  localparam logic [3:0] C_F4_JR_MV    = 4'b1000;
  localparam logic [3:0] C_F4_JALR_ADD = 4'b1001;
  localparam logic [1:0] C_Q2          = 2'b10;

  localparam logic [15:0] C_NOP = 16'h0001;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } packState_e;

  function automatic logic [15:0] crPack(
    input logic [3:0] f4,
    input logic [4:0] r1,
    input logic [4:0] r2
  );
    return {f4, r1, r2, C_Q2};
  endfunction

endpackage

// File: rtl/instruction_cr_compressor_encode.sv
// Combinational RV32I -> CR-format classifier.
// Recognises jr, jalr, mv and add forms; everything else passes through.
module instruction_cr_compressor_encode
  import instruction_cr_compressor_pkg::*;
(
  input  logic [31:0] iINSTR,
  output logic        oCOMPRESSIBLE,
  output logic [15:0] oCINSTR
);

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [11:0] imm;

  logic isJalr;
  logic isAdd;
  logic isJr;
  logic isCJalr;
  logic isMv;
  logic isCAdd;

  assign opcode = iINSTR[6:0];
  assign rd     = iINSTR[11:7];
  assign funct3 = iINSTR[14:12];
  assign rs1    = iINSTR[19:15];
  assign rs2    = iINSTR[24:20];
  assign funct7 = iINSTR[31:25];
  assign imm    = iINSTR[31:20];

  assign isJalr = (opcode == OP_JALR)
               && (funct3 == 3'b000)
               && (imm == 12'd0)
               && (rs1 != 5'd0);

  assign isAdd = (opcode == OP_ADD)
              && (funct3 == 3'b000)
              && (funct7 == 7'd0)
              && (rd != 5'd0)
              && (rs2 != 5'd0);

  assign isJr    = isJalr && (rd == 5'd0);
  assign isCJalr = isJalr && (rd == 5'd1);
  // mv wins over add; rd!=0 keeps the two exclusive
  assign isMv    = isAdd && (rs1 == 5'd0);
  assign isCAdd  = isAdd && (rs1 == rd);

  always_comb begin
    oCOMPRESSIBLE = 1'b0;
    oCINSTR       = 16'd0;
    unique case (1'b1)
      isJr: begin
        oCOMPRESSIBLE = 1'b1;
        oCINSTR = crPack(C_F4_JR_MV, rs1, 5'd0);
      end
      isCJalr: begin
        oCOMPRESSIBLE = 1'b1;
        oCINSTR = crPack(C_F4_JALR_ADD, rs1, 5'd0);
      end
      isMv: begin
        oCOMPRESSIBLE = 1'b1;
        oCINSTR = crPack(C_F4_JR_MV, rd, rs2);
      end
      isCAdd: begin
        oCOMPRESSIBLE = 1'b1;
        oCINSTR = crPack(C_F4_JALR_ADD, rd, rs2);
      end
      default: begin
        oCOMPRESSIBLE = 1'b0;
        oCINSTR       = 16'd0;
      end
    endcase
  end

endmodule

// File: rtl/instruction_cr_compressor.sv
// Packs a stream of RV32I words into a mixed 16/32-bit stream.
// Single registered output slot with valid/ready on both sides.
module instruction_cr_compressor
  import instruction_cr_compressor_pkg::*;
(
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [31:0] iINSTR,
  input  logic        iVALID,
  output logic        oREADY,
  input  logic        iFLUSH,
  output logic [31:0] oWORD,
  output logic        oVALID,
  input  logic        iREADY,
  output logic        oIDLE,
  output logic [15:0] oCOMP_CNT
);

  packState_e  state;
  packState_e  stateNxt;
  logic [15:0] pend;
  logic [15:0] pendNxt;
  logic        compressible;
  logic [15:0] cInstr;
  logic        accept;
  logic        flushReq;
  logic        emit;
  logic [31:0] wordNxt;

  instruction_cr_compressor_encode uEncode (
    .iINSTR        (iINSTR),
    .oCOMPRESSIBLE (compressible),
    .oCINSTR       (cInstr)
  );

  assign oREADY   = !oVALID || iREADY;
  assign accept   = iVALID && oREADY;
  // an incoming instruction always beats a flush
  assign flushReq = iFLUSH && !iVALID && oREADY;
  assign oIDLE    = (state == EMPTY) && !oVALID;

  always_comb begin
    stateNxt = state;
    pendNxt  = pend;
    emit     = 1'b0;
    wordNxt  = oWORD;
    case (state)
      EMPTY: begin
        if (accept) begin
          if (compressible) begin
            pendNxt  = cInstr;
            stateNxt = HALF;
          end else begin
            emit    = 1'b1;
            wordNxt = iINSTR;
          end
        end
      end
      HALF: begin
        if (accept) begin
          emit = 1'b1;
          if (compressible) begin
            wordNxt  = {cInstr, pend};
            stateNxt = EMPTY;
          end else begin
            wordNxt = {iINSTR[15:0], pend};
            pendNxt = iINSTR[31:16];
          end
        end else if (flushReq) begin
          emit     = 1'b1;
          wordNxt  = {C_NOP, pend};
          stateNxt = EMPTY;
        end
      end
      default: begin
        stateNxt = EMPTY;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= EMPTY;
      pend      <= 16'd0;
      oWORD     <= 32'd0;
      oVALID    <= 1'b0;
      oCOMP_CNT <= 16'd0;
    end else begin
      state <= stateNxt;
      pend  <= pendNxt;
      if (oREADY) begin
        oVALID <= emit;
        if (emit) begin
          oWORD <= wordNxt;
        end
      end
      if (accept && compressible
          && (oCOMP_CNT != 16'hFFFF)) begin
        oCOMP_CNT <= oCOMP_CNT + 16'd1;
      end
    end
  end

endmodule
